// File: rtl/sha256_padder_pkg.sv
// Shared constants, state encodings and helpers for the streaming SHA-256 padder.
package sha256_padder_pkg;

  localparam int unsigned SHA256_BLK_BITS   = 512;
  localparam int unsigned SHA256_LEN_BITS   = 64;
  localparam logic [7:0]  SHA256_PAD_BYTE   = 8'h80;
  // Largest final fill that still leaves room for the 8-byte length field.
  localparam int unsigned SHA256_LEN_THRESH = 55;
  localparam int unsigned BLK_BYTES         = 64;
  // Byte-fill counter width, clog2(64)+1 so a full block (64) is representable.
  localparam int unsigned CNT_W             = 7;

  typedef enum logic [1:0] {
    StFill     = 2'd0,
    StEmit     = 2'd1,
    StPadExtra = 2'd2
  } state_e;

  // What the extra trailing block must contain once the current one is taken.
  typedef enum logic [1:0] {
    PendNone     = 2'd0,
    PendExtra80  = 2'd1,
    PendExtraLen = 2'd2
  } pend_e;

  // Trailing block: optional 0x80 marker in byte 0, zero fill, bit length at the end.
  function automatic logic [SHA256_BLK_BITS-1:0] extra_block(input logic with_pad,
                                                             input logic [63:0] len);
    return {(with_pad ? SHA256_PAD_BYTE : 8'h00), 440'h0, len};
  endfunction

endpackage

// File: rtl/sha256_byte_merge.sv
// Combinational byte-lane writer: drops an input beat (and optionally the 0x80 marker
// directly after it) into the 512-bit block buffer at the current fill offset.
module sha256_byte_merge
  import sha256_padder_pkg::*;
#(
  parameter int unsigned IN_BYTES = 4
) (
  input  logic [SHA256_BLK_BITS-1:0]  blk_in,
  input  logic [CNT_W-1:0]            fill,
  input  logic [IN_BYTES*8-1:0]       data,
  input  logic [$clog2(IN_BYTES):0]   nbytes,
  input  logic                        add_pad,
  output logic [SHA256_BLK_BITS-1:0]  blk_out
);

  // Byte i of the block lives at [511-8i -: 8]; beat byte k at the MSB end of data.
  always_comb begin
    blk_out = blk_in;
    for (int i = 0; i < int'(BLK_BYTES); i++) begin
      if ((i >= int'(fill)) && (i < int'(fill) + int'(nbytes)) &&
          (i - int'(fill) < int'(IN_BYTES))) begin
        blk_out[(63 - i) * 8 +: 8] = data[(int'(IN_BYTES) - 1 - (i - int'(fill))) * 8 +: 8];
      end else if (add_pad && (i == int'(fill) + int'(nbytes))) begin
        blk_out[(63 - i) * 8 +: 8] = SHA256_PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// Streaming SHA-256 message padder: byte beats in, fully padded 512-bit blocks out.
// Optional block index output enabled by defining SHA_PAD_BLKCNT_EN.
module sha256_padder
  import sha256_padder_pkg::*;
#(
  parameter int unsigned IN_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_BYTES*8-1:0]       in_data,
  input  logic [$clog2(IN_BYTES):0]   in_nbytes,
  input  logic                        in_last,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [SHA256_BLK_BITS-1:0]  blk_data,
  output logic                        blk_first,
`ifdef SHA_PAD_BLKCNT_EN
  output logic [31:0]                 blk_cnt,
`endif
  output logic                        blk_last
);

  state_e                      state;
  pend_e                       pending;
  logic [CNT_W-1:0]            fill;
  logic [SHA256_LEN_BITS-1:0]  bit_len;

  logic                        accept;
  logic [CNT_W-1:0]            new_fill;
  logic [SHA256_LEN_BITS-1:0]  new_len;
  logic [SHA256_BLK_BITS-1:0]  merged;

  // in_ready is only ever high in FILL, so it alone qualifies a beat.
  assign accept = in_valid & in_ready;

  // Fill position and running bit length after the current beat.
  always_comb begin
    new_fill = fill + CNT_W'(in_nbytes);
    new_len  = bit_len + (SHA256_LEN_BITS'(in_nbytes) << 3);
  end

  sha256_byte_merge #(
    .IN_BYTES (IN_BYTES)
  ) u_merge (
    .blk_in  (blk_data),
    .fill    (fill),
    .data    (in_data),
    .nbytes  (in_nbytes),
    .add_pad (in_last),
    .blk_out (merged)
  );

  // Padder FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StFill;
      pending   <= PendNone;
      fill      <= '0;
      bit_len   <= '0;
      blk_data  <= '0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b1;
      blk_last  <= 1'b0;
`ifdef SHA_PAD_BLKCNT_EN
      blk_cnt   <= '0;
`endif
    end else begin
      case (state)
        StFill: begin
          in_ready <= 1'b1;
          if (accept) begin
            blk_data <= merged;
            fill     <= new_fill;
            bit_len  <= new_len;
            if (in_last) begin
              state     <= StEmit;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              if (new_fill <= CNT_W'(SHA256_LEN_THRESH)) begin
                // Length fits: bytes 56..63 are still zero, overwrite them.
                blk_data <= {merged[SHA256_BLK_BITS-1:SHA256_LEN_BITS], new_len};
                blk_last <= 1'b1;
              end else if (new_fill < CNT_W'(BLK_BYTES)) begin
                pending <= PendExtraLen;
              end else begin
                pending <= PendExtra80;
              end
            end else if (new_fill == CNT_W'(BLK_BYTES)) begin
              state     <= StEmit;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
            end
          end
        end

        StEmit: begin
          if (blk_ready) begin
            blk_data  <= '0;
            fill      <= '0;
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
`ifdef SHA_PAD_BLKCNT_EN
            blk_cnt   <= blk_last ? 32'd0 : blk_cnt + 32'd1;
`endif
            if (pending != PendNone) begin
              state <= StPadExtra;
            end else if (blk_last) begin
              state     <= StFill;
              in_ready  <= 1'b1;
              bit_len   <= '0;
              blk_first <= 1'b1;
              blk_last  <= 1'b0;
            end else begin
              state    <= StFill;
              in_ready <= 1'b1;
            end
          end
        end

        StPadExtra: begin
          blk_data  <= extra_block(pending == PendExtra80, bit_len);
          blk_last  <= 1'b1;
          pending   <= PendNone;
          blk_valid <= 1'b1;
          state     <= StEmit;
        end

        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder (IN_BYTES=4): table of messages checked
// against a byte-level padding model, plus hand-written abc / stall / reset sequences.
module tb_sha256_padder;

  localparam int IN_BYTES = 4;
  localparam int NB_W     = $clog2(IN_BYTES) + 1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [NB_W-1:0]  in_nbytes;
  logic             in_last;
  logic             blk_valid;
  logic             blk_ready;
  logic [511:0]     blk_data;
  logic             blk_first;
  logic             blk_last;
`ifdef SHA_PAD_BLKCNT_EN
  logic [31:0]      blk_cnt;
`endif

  sha256_padder #(
    .IN_BYTES (IN_BYTES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
`ifdef SHA_PAD_BLKCNT_EN
    .blk_cnt   (blk_cnt),
`endif
    .blk_last  (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Blocks seen by the consumer, recorded the half-cycle before each handshake edge.
  logic [511:0] got_q[$];
  bit           gf_q[$];
  bit           gl_q[$];
  int           gc_q[$];

  always @(negedge clk) begin
    if (reset && blk_valid && blk_ready) begin
      got_q.push_back(blk_data);
      gf_q.push_back(blk_first);
      gl_q.push_back(blk_last);
      gc_q.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (reset && in_valid && in_ready)
      assert (in_nbytes <= NB_W'(IN_BYTES)) else $error("illegal in_nbytes %0d", in_nbytes);
  end

  typedef struct {
    int          len;
    logic [7:0]  pat;
    int          nblk;
    logic [63:0] len_bits;
    bit          chk_gap;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    gf_q.delete();
    gl_q.delete();
    gc_q.delete();
  endtask

  // Present one beat and hold it until the DUT takes it; returns at posedge+1.
  task automatic send_beat(input logic [31:0] d, input int nb, input bit last);
    bit done;
    done      = 0;
    in_data   = d;
    in_nbytes = nb[NB_W-1:0];
    in_last   = last;
    in_valid  = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got timeout want accept");
    end
  endtask

  task automatic send_msg(input int len, input logic [7:0] pat);
    int off;
    int rem;
    int nb;
    logic [31:0] d;
    off = 0;
    forever begin
      rem = len - off;
      nb  = (rem < IN_BYTES) ? rem : IN_BYTES;
      d   = '0;
      for (int k = 0; k < nb; k++) d[(3 - k) * 8 +: 8] = pat;
      send_beat(d, nb, rem <= IN_BYTES);
      if (rem <= IN_BYTES) break;
      off += IN_BYTES;
    end
  endtask

  // Wait for the consumer to take a block flagged last.
  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk);
      if (gl_q.size() > 0 && gl_q[gl_q.size() - 1]) ok = 1;
    end
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_last: got timeout want last block");
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit [7:0]     pm[$];
    logic [511:0] exp_q[$];
    logic [511:0] blk;
    logic [63:0]  lbits;
    int           ng;
    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian length.
    for (int j = 0; j < v.len; j++) pm.push_back(v.pat);
    pm.push_back(8'h80);
    while (pm.size() % 64 != 56) pm.push_back(8'h00);
    lbits = 64'(v.len) * 64'd8;
    for (int k = 7; k >= 0; k--) pm.push_back(lbits[k * 8 +: 8]);
    for (int b = 0; b < pm.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[(63 - j) * 8 +: 8] = pm[b * 64 + j];
      exp_q.push_back(blk);
    end

    clear_q();
    send_msg(v.len, v.pat);
    wait_done();
    ng = got_q.size();
    check($sformatf("v%0d_nblk", idx), 512'(ng), 512'(v.nblk));
    for (int b = 0; b < ng && b < exp_q.size(); b++) begin
      check($sformatf("v%0d_blk%0d_data", idx, b), got_q[b], exp_q[b]);
      check($sformatf("v%0d_blk%0d_first", idx, b), 512'(gf_q[b]), 512'(b == 0));
      check($sformatf("v%0d_blk%0d_last", idx, b), 512'(gl_q[b]), 512'(b == exp_q.size() - 1));
    end
    if (ng > 0) check($sformatf("v%0d_len", idx), 512'(got_q[ng - 1][63:0]), 512'(v.len_bits));
    if (v.chk_gap && ng >= 2)
      check($sformatf("v%0d_extra_gap", idx), 512'(gc_q[ng - 1] - gc_q[ng - 2]), 512'd2);
  endtask

  task automatic run_abc(input string tag);
    clear_q();
    send_beat(32'h61626300, 3, 1'b1);
    @(negedge clk);
    check({tag, "_latency"}, 512'(blk_valid), 512'd1);
    wait_done();
    check({tag, "_nblk"}, 512'(got_q.size()), 512'd1);
    if (got_q.size() > 0) begin
      check({tag, "_data"}, got_q[0], ABC_BLK);
      check({tag, "_first"}, 512'(gf_q[0]), 512'd1);
      check({tag, "_last"}, 512'(gl_q[0]), 512'd1);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_blk_valid", 512'(blk_valid), 512'd0);
    check("rst_in_ready", 512'(in_ready), 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0,   8'h00, 1, 64'h000, 1'b0};
    vecs[1] = '{55,  8'h41, 1, 64'h1B8, 1'b0};
    vecs[2] = '{56,  8'h41, 2, 64'h1C0, 1'b1};
    vecs[3] = '{64,  8'h00, 2, 64'h200, 1'b1};
    vecs[4] = '{60,  8'h5A, 2, 64'h1E0, 1'b1};
    vecs[5] = '{100, 8'h11, 2, 64'h320, 1'b0};
    vecs[6] = '{120, 8'h33, 3, 64'h3C0, 1'b1};
    vecs[7] = '{128, 8'h77, 3, 64'h400, 1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_last   = 1'b0;
    blk_ready = 1'b1;

    #12;
    check("reset_in_ready", 512'(in_ready), 512'd0);
    check("reset_blk_valid", 512'(blk_valid), 512'd0);
    check("reset_blk_first", 512'(blk_first), 512'd1);
    check("reset_blk_last", 512'(blk_last), 512'd0);
    check("reset_blk_data", blk_data, 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;

    run_abc("abc");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: block held stable, no beats taken, then reset mid-EMIT.
    blk_ready = 1'b0;
    clear_q();
    send_beat(32'h61626300, 3, 1'b1);
    in_data   = 32'hDEADBEEF;
    in_nbytes = NB_W'(IN_BYTES);
    in_last   = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check($sformatf("stall%0d_data", n), blk_data, ABC_BLK);
      check($sformatf("stall%0d_valid", n), 512'(blk_valid), 512'd1);
      check($sformatf("stall%0d_in_ready", n), 512'(in_ready), 512'd0);
    end
    pulse_reset();
    blk_ready = 1'b1;

    // Partial message then reset: must be discarded.
    send_beat(32'h01020304, 4, 1'b0);
    pulse_reset();
    check("discard_nblk", 512'(got_q.size()), 512'd0);

    run_abc("abc_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Streaming SHA-256 message padder: accepts a byte-oriented message over a valid/ready input, emits fully padded 512-bit blocks (FIPS 180-4 padding: 0x80, zero fill, 64-bit big-endian bit length).
- Handles arbitrary message lengths across multiple blocks.
- Replaces the fixed single-block padding function; sits directly upstream of message_scheduler, which consumes blk_data as its block input.

Parameters:
- IN_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64).
- CNT_W, 7, width of byte-fill counter; fixed at clog2(64)+1; not user-overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  padder can accept a beat.
- in_data  input  IN_BYTES*8  message bytes; first byte in the MSBs.
- in_nbytes  input  clog2(IN_BYTES)+1  valid byte count; must equal IN_BYTES unless in_last; 0..IN_BYTES on last beat, left-justified.
- in_last  input  1  final beat of message.
- blk_valid  output  1  padded block valid.
- blk_ready  input  1  downstream accepts block.
- blk_data  output  512  padded block; message byte 0 of block at [511:504].
- blk_first  output  1  block is first of message.
- blk_last  output  1  block is final of message (carries length).

Behaviour:
- Reset, asynchronous while reset==0: state=FILL, fill count 0, 64-bit bit-length 0, buffer 0, in_ready=0 during reset then 1, blk_valid=0, blk_first=1 (internal flag), blk_last=0.
- States: FILL, EMIT, PAD_EXTRA.
- FILL:
  - in_ready=1.
  - Accepted beat writes in_nbytes bytes at the fill position; fill count and bit-length advance by in_nbytes and in_nbytes*8.
  - Fill reaches 64 with no in_last -> EMIT, block is a data block, blk_last=0.
  - in_last with final fill F (0..64):
    - F<=55: write 0x80 at byte F, zeros, length at [63:0]; -> EMIT, blk_last=1.
    - 56<=F<=63: write 0x80 at F, zeros to end; -> EMIT, blk_last=0, pending=EXTRA_LEN.
    - F==64: -> EMIT, blk_last=0, pending=EXTRA_80.
- EMIT:
  - in_ready=0, blk_valid=1, blk_data/blk_first/blk_last stable until blk_ready.
  - On blk_ready: clear buffer and fill count, blk_first flag<=0.
  - If pending -> PAD_EXTRA.
  - If blk_last -> FILL with bit-length<=0 and blk_first flag<=1.
  - Otherwise -> FILL.
- PAD_EXTRA: one cycle builds the extra block, then -> EMIT with blk_last=1.
  - EXTRA_80: 0x80 at byte 0, zeros, length.
  - EXTRA_LEN: all zeros plus length.
- Latency: blk_valid asserts the cycle after the beat that completes a block; the extra block is 2 cycles after first-block acceptance.
- Backpressure: blk_ready held low holds EMIT indefinitely; no input accepted meanwhile.
- in_valid with in_ready=0 is ignored; input need not hold.
- Bit-length wraps modulo 2^64 (no saturation).
- in_nbytes > IN_BYTES is illegal; behaviour undefined (assertion in bench).
- Reset mid-message or mid-EMIT discards the partial message; the next accepted beat starts a new message.

Optional Feature:
- SHA_PAD_BLKCNT_EN defined: adds output blk_cnt [31:0], the index of the current block within its message.
  - 0 on the first block; increments on each accepted block; cleared after the blk_last handshake and on reset.
- Undefined: port and counter are absent.

Decomposition:
- Shared package/include (defines.vh): SHA256_BLK_BITS=512, SHA256_LEN_BITS=64, SHA256_PAD_BYTE=8'h80, the 55-byte length threshold, and the state encodings (FILL/EMIT/PAD_EXTRA).
- Natural sub-module: sha256_byte_merge, a combinational byte-lane writer that inserts an IN_BYTES beat plus an optional 0x80 at the fill offset into the 512-bit buffer.

Test Plan:
- "abc", IN_BYTES=4, one beat 0x61626300, in_nbytes=3, last -> one block 0x61626380 followed by zeros; [63:0]=0x18; blk_first=blk_last=1.
- Empty message (in_nbytes=0, last) -> blk_data=0x80 followed by 63 zero bytes, length 0; first=last=1.
- 55 bytes of 0x41 -> single block, byte55=0x80, [63:0]=0x1B8.
- 56 bytes of 0x41 -> block1 byte56=0x80, blk_last=0; block2 all zero plus [63:0]=0x1C0, blk_last=1.
- 64 bytes of 0x00 -> block1 all zero; block2 [511:504]=0x80, [63:0]=0x200.
- blk_ready held low 20 cycles, then reset pulsed low mid-message -> blk_data stable while stalled, no beats accepted; after reset, "abc" yields the same result as the first scenario.
- "abc" through message_scheduler and sha256_pipeline -> final hash ba7816bf...f20015ad.
